// File: rtl/audio_chan_ctrl.sv
// Multi-channel audio control register bank.
// Each channel holds volume, sound select and a ramp target. A channel can
// be set immediately, faded one LSB per prescaler tick toward a target, or
// stopped. A shared free-running prescaler paces all fades.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | channel stopped (or never started), volume 0
//   ST_PLAY  | channel active, volume steady
//   ST_RAMP  | channel active, volume stepping toward target each tick
module audio_chan_ctrl #(
  parameter int NUM_CH   = 4,
  parameter int VOL_W    = 5,
  parameter int SEL_W    = 4,
  parameter int RAMP_DIV = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      audio_wr,
  input  logic [31:0]               audio_cmd,
  output logic [NUM_CH*VOL_W-1:0]   vol_out,
  output logic [NUM_CH*SEL_W-1:0]   sel_out,
  output logic [NUM_CH-1:0]         ch_active,
  output logic [NUM_CH-1:0]         ch_busy,
  output logic [NUM_CH-1:0]         ch_trig,
  output logic                      cmd_err
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PS_W   = $clog2(RAMP_DIV);
  localparam int R_BIT  = VOL_W + SEL_W;
  localparam int S_BIT  = R_BIT + 1;
  localparam int CH_LSB = S_BIT + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_RAMP
  } ch_state_t;

  logic [VOL_W-1:0] cmd_vol;
  logic [SEL_W-1:0] cmd_sel;
  logic             cmd_ramp;
  logic             cmd_stop;
  logic [CH_W-1:0]  cmd_ch;
  logic             cmd_valid;
  logic             unused_cmd_bits;

  assign cmd_vol   = audio_cmd[VOL_W-1:0];
  assign cmd_sel   = audio_cmd[R_BIT-1:VOL_W];
  assign cmd_ramp  = audio_cmd[R_BIT];
  assign cmd_stop  = audio_cmd[S_BIT];
  assign cmd_ch    = audio_cmd[CH_LSB +: CH_W];
  assign cmd_valid = (32'(cmd_ch) < NUM_CH);
  // Upper instruction bits carry nothing for this block.
  assign unused_cmd_bits = ^audio_cmd[31:CH_LSB+CH_W];

  logic [PS_W-1:0] ps_cnt;
  logic            tick;

  assign tick = (ps_cnt == PS_W'(RAMP_DIV - 1));

  // Shared prescaler: free-running 0..RAMP_DIV-1, ticks on its last count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps_cnt <= '0;
    end else if (tick) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + 1'b1;
    end
  end

  // Error pulse for commands aimed past the last implemented channel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_err <= 1'b0;
    end else begin
      cmd_err <= audio_wr && !cmd_valid;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    ch_state_t        state_q;
    logic [VOL_W-1:0] vol_q;
    logic [VOL_W-1:0] target_q;
    logic [SEL_W-1:0] sel_q;
    logic             active_q;
    logic             busy_q;
    logic             trig_q;
    logic             hit;
    logic [VOL_W-1:0] vol_step;

    assign hit      = audio_wr && cmd_valid && (32'(cmd_ch) == k);
    // Ramps only run while vol != target, so the step can never wrap.
    assign vol_step = (vol_q < target_q) ? vol_q + 1'b1 : vol_q - 1'b1;

    // Channel FSM: a command to this channel always wins over a ramp step.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q  <= ST_IDLE;
        vol_q    <= '0;
        target_q <= '0;
        sel_q    <= '0;
        active_q <= 1'b0;
        busy_q   <= 1'b0;
        trig_q   <= 1'b0;
      end else begin
        trig_q <= 1'b0;
        if (hit) begin
          if (cmd_stop) begin
            state_q  <= ST_IDLE;
            vol_q    <= '0;
            target_q <= '0;
            active_q <= 1'b0;
            busy_q   <= 1'b0;
          end else if (!cmd_ramp) begin
            state_q  <= ST_PLAY;
            vol_q    <= cmd_vol;
            target_q <= cmd_vol;
            sel_q    <= cmd_sel;
            active_q <= 1'b1;
            busy_q   <= 1'b0;
            trig_q   <= 1'b1;
          end else begin
            target_q <= cmd_vol;
            sel_q    <= cmd_sel;
            active_q <= 1'b1;
            trig_q   <= 1'b1;
            if (cmd_vol == vol_q) begin
              state_q <= ST_PLAY;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_RAMP;
              busy_q  <= 1'b1;
            end
          end
        end else if (state_q == ST_RAMP && tick) begin
          vol_q <= vol_step;
          if (vol_step == target_q) begin
            state_q <= ST_PLAY;
            busy_q  <= 1'b0;
          end
        end
      end
    end

    assign vol_out[k*VOL_W +: VOL_W] = vol_q;
    assign sel_out[k*SEL_W +: SEL_W] = sel_q;
    assign ch_active[k]              = active_q;
    assign ch_busy[k]                = busy_q;
    assign ch_trig[k]                = trig_q;
  end

endmodule

// File: tb/tb_audio_chan_ctrl.sv
// Bench for audio_chan_ctrl: directed scenarios plus random commands, all
// compared cycle by cycle against a per-channel behavioural model.
module tb_audio_chan_ctrl;

  localparam int NUM_CH   = 3;
  localparam int VOL_W    = 5;
  localparam int SEL_W    = 4;
  localparam int RAMP_DIV = 4;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    audio_wr = 1'b0;
  logic [31:0]             audio_cmd = '0;
  logic [NUM_CH*VOL_W-1:0] vol_out;
  logic [NUM_CH*SEL_W-1:0] sel_out;
  logic [NUM_CH-1:0]       ch_active;
  logic [NUM_CH-1:0]       ch_busy;
  logic [NUM_CH-1:0]       ch_trig;
  logic                    cmd_err;

  audio_chan_ctrl #(
    .NUM_CH(NUM_CH), .VOL_W(VOL_W), .SEL_W(SEL_W), .RAMP_DIV(RAMP_DIV)
  ) dut (
    .clk(clk), .reset(reset), .audio_wr(audio_wr), .audio_cmd(audio_cmd),
    .vol_out(vol_out), .sel_out(sel_out), .ch_active(ch_active),
    .ch_busy(ch_busy), .ch_trig(ch_trig), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: plain per-channel numbers, cycle counter for ticks.
  int m_vol [NUM_CH];
  int m_sel [NUM_CH];
  int m_tgt [NUM_CH];
  bit m_act [NUM_CH];
  bit m_busy[NUM_CH];
  bit m_trig[NUM_CH];
  bit m_err;
  int m_cnt;

  function automatic logic [31:0] mk(int ch, int s, int r, int sel, int vol);
    return 32'((ch << 11) | (s << 10) | (r << 9) | (sel << 5) | vol);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_vol[i] = 0; m_sel[i] = 0; m_tgt[i] = 0;
      m_act[i] = 0; m_busy[i] = 0; m_trig[i] = 0;
    end
    m_err = 0;
    m_cnt = 0;
  endtask

  task automatic model_edge(bit wr, logic [31:0] cmd);
    bit tk;
    int ch, vol, sel, r, s;
    tk  = (m_cnt == RAMP_DIV - 1);
    vol = int'(cmd[4:0]);
    sel = int'(cmd[8:5]);
    r   = int'(cmd[9]);
    s   = int'(cmd[10]);
    ch  = int'(cmd[12:11]);
    m_cnt = tk ? 0 : m_cnt + 1;
    m_err = wr && (ch >= NUM_CH);
    for (int i = 0; i < NUM_CH; i++) begin
      m_trig[i] = 0;
      if (wr && ch == i) begin
        if (s != 0) begin
          m_vol[i] = 0; m_act[i] = 0; m_busy[i] = 0; m_tgt[i] = 0;
        end else begin
          m_sel[i] = sel; m_act[i] = 1; m_trig[i] = 1; m_tgt[i] = vol;
          if (r == 0) begin
            m_vol[i] = vol; m_busy[i] = 0;
          end else begin
            m_busy[i] = (vol != m_vol[i]);
          end
        end
      end else if (m_busy[i] && tk) begin
        m_vol[i] = m_vol[i] + ((m_vol[i] < m_tgt[i]) ? 1 : -1);
        if (m_vol[i] == m_tgt[i]) m_busy[i] = 0;
      end
    end
  endtask

  task automatic chk(string tag, string name, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s %s: observed %0h expected %0h", tag, name, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [NUM_CH*VOL_W-1:0] ev;
    logic [NUM_CH*SEL_W-1:0] es;
    logic [NUM_CH-1:0]       ea, eb, et;
    for (int i = 0; i < NUM_CH; i++) begin
      ev[i*VOL_W +: VOL_W] = VOL_W'(m_vol[i]);
      es[i*SEL_W +: SEL_W] = SEL_W'(m_sel[i]);
      ea[i] = m_act[i];
      eb[i] = m_busy[i];
      et[i] = m_trig[i];
    end
    chk(tag, "vol_out",   64'(vol_out),   64'(ev));
    chk(tag, "sel_out",   64'(sel_out),   64'(es));
    chk(tag, "ch_active", 64'(ch_active), 64'(ea));
    chk(tag, "ch_busy",   64'(ch_busy),   64'(eb));
    chk(tag, "ch_trig",   64'(ch_trig),   64'(et));
    chk(tag, "cmd_err",   64'(cmd_err),   64'(m_err));
  endtask

  task automatic cyc(bit wr, logic [31:0] cmd, string tag);
    audio_wr  = wr;
    audio_cmd = cmd;
    @(posedge clk);
    if (reset) model_edge(wr, cmd);
    #1;
    audio_wr = 1'b0;
    check_all(tag);
  endtask

  logic [VOL_W-1:0] v0_before;

  initial begin
    model_reset();
    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b1;
    for (int i = 0; i < 10; i++) cyc(0, '0, "idle");

    // Immediate write ch2 vol 20 sel 3
    cyc(1, mk(2, 0, 0, 3, 20), "imm_ch2");
    chk("imm_ch2", "vol2", 64'(vol_out[14:10]), 64'd20);
    chk("imm_ch2", "sel2", 64'(sel_out[11:8]), 64'd3);
    chk("imm_ch2", "trig", 64'(ch_trig), 64'b100);
    cyc(0, '0, "imm_ch2_after");

    // Ramp ch0 from 0 to 3
    cyc(1, mk(0, 0, 1, 1, 3), "ramp_ch0");
    chk("ramp_ch0", "busy0", 64'(ch_busy[0]), 64'd1);
    for (int i = 0; i < 16; i++) cyc(0, '0, "ramp_ch0_run");
    chk("ramp_ch0", "vol0_final", 64'(vol_out[4:0]), 64'd3);

    // Ramp ch1 10 -> 0, interrupted after two steps by immediate vol 7
    cyc(1, mk(1, 0, 0, 2, 10), "ch1_set10");
    cyc(1, mk(1, 0, 1, 2, 0), "ch1_ramp0");
    for (int i = 0; i < 40 && m_vol[1] != 8; i++) cyc(0, '0, "ch1_ramp_run");
    chk("ch1_ramp", "vol1_after2", 64'(vol_out[9:5]), 64'd8);
    cyc(1, mk(1, 0, 0, 2, 7), "ch1_abort");
    for (int i = 0; i < 12; i++) cyc(0, '0, "ch1_hold");
    chk("ch1_abort", "vol1_hold", 64'(vol_out[9:5]), 64'd7);

    // Write on a tick edge: commanded channel holds, other channel steps
    cyc(1, mk(0, 0, 1, 1, 20), "ch0_ramp20");
    cyc(1, mk(1, 0, 1, 2, 0), "ch1_ramp0b");
    for (int i = 0; i < 8 && m_cnt != RAMP_DIV - 1; i++) cyc(0, '0, "align");
    v0_before = vol_out[4:0];
    cyc(1, mk(0, 0, 1, 5, 20), "tick_write");
    chk("tick_write", "vol0_nostep", 64'(vol_out[4:0]), 64'(v0_before));
    for (int i = 0; i < 12; i++) cyc(0, '0, "tick_write_run");

    // Stop ch2: sel kept, no trigger
    cyc(1, mk(2, 1, 0, 9, 9), "stop_ch2");
    chk("stop_ch2", "sel2_kept", 64'(sel_out[11:8]), 64'd3);
    chk("stop_ch2", "active2", 64'(ch_active[2]), 64'd0);

    // Nonexistent channel
    cyc(1, mk(3, 0, 0, 7, 9), "bad_ch");
    chk("bad_ch", "cmd_err", 64'(cmd_err), 64'd1);
    cyc(0, '0, "bad_ch_after");

    // Random commands, upper instruction bits randomised as well
    for (int i = 0; i < 600; i++) begin
      logic [31:0] c;
      c = mk($urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? 1 : 0,
             $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 31));
      c = c | ($urandom() & 32'hFFFF_E000);
      cyc($urandom_range(0, 2) == 0, c, "random");
    end

    // Asynchronous reset in the middle of a ramp
    cyc(1, mk(0, 0, 0, 1, 0), "pre_reset_set");
    cyc(1, mk(0, 0, 1, 1, 31), "pre_reset_ramp");
    for (int i = 0; i < 6; i++) cyc(0, '0, "pre_reset_run");
    chk("pre_reset", "busy0", 64'(ch_busy[0]), 64'd1);
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(posedge clk);
    #1;
    check_all("reset_hold");
    reset = 1'b1;
    for (int i = 0; i < 8; i++) cyc(0, '0, "post_reset");
    cyc(1, mk(1, 0, 1, 4, 2), "post_reset_ramp");
    for (int i = 0; i < 12; i++) cyc(0, '0, "post_reset_run");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_chan_ctrl.md
Name: audio_chan_ctrl

Overview:
Multi-channel audio control register bank for the decode stage. It generalises the single volume/sound-select register pair to NUM_CH independent channels. Each channel supports immediate or ramped (stepped fade) volume changes, explicit stop, and a one-cycle trigger pulse to the audio engine. Commands arrive as the decoded instruction word qualified by the decode-stage audio strobe.

Parameters:
NUM_CH, 4, number of audio channels (1..16)
VOL_W, 5, volume field width per channel
SEL_W, 4, sound-select field width per channel
RAMP_DIV, 256, clock cycles per one-LSB volume step in ramp mode (>=2)
(derived localparam CH_W = max(1, clog2(NUM_CH)); VOL_W+SEL_W+2+CH_W <= 26)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
audio_wr  in  1  command strobe from decode control, one command per cycle
audio_cmd  in  32  instruction word; fields below
vol_out  out  NUM_CH*VOL_W  current volume, channel k at [k*VOL_W +: VOL_W]
sel_out  out  NUM_CH*SEL_W  current sound select, channel k at [k*SEL_W +: SEL_W]
ch_active  out  NUM_CH  channel playing
ch_busy  out  NUM_CH  ramp in progress
ch_trig  out  NUM_CH  one-cycle start pulse per channel
cmd_err  out  1  one-cycle pulse: command addressed a nonexistent channel

Behaviour:
- Command fields: target volume = cmd[VOL_W-1:0]; select = cmd[VOL_W+SEL_W-1:VOL_W]; ramp bit R = cmd[VOL_W+SEL_W]; stop bit S = cmd[VOL_W+SEL_W+1]; channel = cmd[VOL_W+SEL_W+2 +: CH_W]. Bits above are ignored.
- Reset (reset=0, async): all vol/sel/target = 0; ch_active, ch_busy, ch_trig, cmd_err = 0; prescaler = 0. On release, all state starts from zero at the next edge.
- All registered. Every command takes effect on the clk edge where audio_wr=1 is sampled. ch_trig/cmd_err are high for exactly the following cycle.
- Prescaler: single free-running counter 0..RAMP_DIV-1, shared by all channels. tick = (count == RAMP_DIV-1). It wraps to 0 and runs regardless of commands.
- Per-channel state machine IDLE / PLAY / RAMP:
  - S=1 (stop, overrides R): vol<=0, active<=0, busy<=0, target<=0, sel unchanged, no trig. The next state is IDLE.
  - S=0, R=0 (immediate): vol<=target field, sel<=select, active<=1, busy<=0 (aborts any ramp), trig pulse. The next state is PLAY.
  - S=0, R=1 (ramp): sel<=select, target<=field, active<=1, trig pulse. If field == current vol, busy<=0 and the next state is PLAY. Otherwise busy<=1 and the next state is RAMP. vol is unchanged in the command cycle.
  - RAMP: on each tick, vol steps by +1 toward target if vol<target, or -1 if vol>target.
  - When the stepped vol equals target, busy falls on that same edge and the channel enters PLAY. A ramp to 0 leaves active=1.
- A write to a channel on the same edge as a tick: the command wins and no step occurs for that channel that cycle. Other channels step normally.
- Channel index >= NUM_CH: no state change, cmd_err pulse, no trig.
- Volume never wraps. Steps saturate exactly at target, which lies within 0..2^VOL_W-1.
- Reset asserted mid-ramp: immediate return to reset values; no residual busy or trig.
- audio_wr=0: only the prescaler and ramp steps advance.

Test Plan:
1. Assert reset for 3 cycles, then release -> every output 0. Still 0 after 10 idle cycles.
2. NUM_CH=4. Immediate write: ch2, vol 20, sel 3 -> next edge: vol_out[14:10]=20, sel_out[11:8]=3, ch_active=4'b0100, ch_trig=4'b0100 for one cycle, ch_busy=0.
3. RAMP_DIV=4. Ramp write: ch0, vol 0 -> target 3 -> busy=1. vol steps to 1, 2, 3 on three consecutive ticks, 4 cycles apart. busy drops on the edge vol becomes 3. trig pulses once, only after the command.
4. Ramp ch1 from 10 toward 0. After 2 steps, issue immediate vol 7 on ch1 -> vol=7, busy=0, no further steps. Also issue a write coinciding with a tick -> no step that cycle.
5. Stop ch2 while active with sel 3 -> vol 0, active 0, sel remains 3, no trig.
6. NUM_CH=3, write to channel 3 -> cmd_err one-cycle pulse, all channel outputs unchanged. Assert reset mid-ramp on ch0 -> busy, vol and active cleared immediately (asynchronously).
